// File: rtl/tour_cmd_if.sv
// tour_cmd_if: bundles the tour_cmd solver, robot and status signals
//   start_tour  : solver -> block, one-cycle replay start pulse
//   mv_indx[4:0]: block -> solver, move index into the move store
//   move[7:0]   : solver -> block, one-hot move (registered in the solver)
//   cmd[15:0]   : block -> robot, {opcode, heading, square count}
//   cmd_rdy     : block -> robot, cmd valid until clr_cmd_rdy
//   clr_cmd_rdy : robot -> block, cmd accepted
//   resp_rdy    : robot -> block, command finished pulse
//   tour_done   : block -> system, one-cycle pulse after the final move
//   mv_err      : block -> system, sticky non-one-hot move flag
// Modport slave is the tour_cmd side, master is the solver/robot side.
interface tour_cmd_if;
  logic start_tour;
  logic [4:0] mv_indx;
  logic [7:0] move;
  logic [15:0] cmd;
  logic cmd_rdy;
  logic clr_cmd_rdy;
  logic resp_rdy;
  logic tour_done;
  logic mv_err;
  modport slave(input start_tour, move, clr_cmd_rdy, resp_rdy,
                output mv_indx, cmd, cmd_rdy, tour_done, mv_err);
  modport master(output start_tour, move, clr_cmd_rdy, resp_rdy,
                 input mv_indx, cmd, cmd_rdy, tour_done, mv_err);
endinterface

// File: rtl/tour_cmd.sv
// tour_cmd: replays a knight's tour as vertical then horizontal robot move commands
//   clk, rst : system clock, synchronous active-high reset
//   bus      : tour_cmd_if.slave (start_tour, mv_indx, move, cmd, cmd_rdy,
//              clr_cmd_rdy, resp_rdy, tour_done, mv_err)
//   NUM_MOVES: number of moves replayed per tour
//   TOUR_CMD_FANFARE_EN: when defined the horizontal leg uses opcode 4'h3
module tour_cmd #(
  parameter int NUM_MOVES = 24
) (
  input logic clk,
  input logic rst,
  tour_cmd_if.slave bus
);
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, VERT, VWAIT, HORZ, HWAIT, DONE} state_t;
`ifdef TOUR_CMD_FANFARE_EN
  localparam logic [3:0] OP_H = 4'h3;
`else
  localparam logic [3:0] OP_H = 4'h2;
`endif
  localparam logic [4:0] LAST = 5'(NUM_MOVES - 1);
  state_t state_q, state_d;
  logic [4:0] mv_indx_q, mv_indx_d;
  logic [15:0] cmd_q, cmd_d;
  logic [7:0] move_q, move_d;
  logic cmd_rdy_q, cmd_rdy_d, mv_err_q, mv_err_d;
  logic one_hot;
  logic [15:0] v_cmd, h_cmd;
  assign one_hot = (bus.move != 8'h00) && ((bus.move & (bus.move - 8'd1)) == 8'h00);
  // Masks group the eight knight moves by sign and magnitude of dy / dx.
  assign v_cmd = {4'h2, |(move_q & 8'h87) ? 8'h00 : 8'h7F, |(move_q & 8'h33) ? 4'd2 : 4'd1};
  assign h_cmd = {OP_H, |(move_q & 8'hE1) ? 8'hBF : 8'h3F, |(move_q & 8'hCC) ? 4'd2 : 4'd1};
  always_comb begin
    state_d = state_q;
    mv_indx_d = mv_indx_q;
    cmd_d = cmd_q;
    move_d = move_q;
    cmd_rdy_d = cmd_rdy_q;
    mv_err_d = mv_err_q;
    case (state_q)
      IDLE: if (bus.start_tour) begin
        state_d = FETCH;
        mv_indx_d = '0;
        mv_err_d = 1'b0;
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        move_d = bus.move;
        state_d = one_hot ? VERT : IDLE;
        mv_err_d = mv_err_q | ~one_hot;
      end
      // First cycle of a leg loads cmd; clr only counts once cmd_rdy is up.
      VERT: if (!cmd_rdy_q) begin
        cmd_d = v_cmd;
        cmd_rdy_d = 1'b1;
      end else if (bus.clr_cmd_rdy) begin
        cmd_rdy_d = 1'b0;
        state_d = VWAIT;
      end
      VWAIT: state_d = bus.resp_rdy ? HORZ : VWAIT;
      HORZ: if (!cmd_rdy_q) begin
        cmd_d = h_cmd;
        cmd_rdy_d = 1'b1;
      end else if (bus.clr_cmd_rdy) begin
        cmd_rdy_d = 1'b0;
        state_d = HWAIT;
      end
      HWAIT: if (bus.resp_rdy) begin
        state_d = (mv_indx_q == LAST) ? DONE : FETCH;
        mv_indx_d = (mv_indx_q == LAST) ? mv_indx_q : mv_indx_q + 5'd1;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mv_indx_q <= '0;
      cmd_q <= '0;
      move_q <= '0;
      cmd_rdy_q <= 1'b0;
      mv_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mv_indx_q <= mv_indx_d;
      cmd_q <= cmd_d;
      move_q <= move_d;
      cmd_rdy_q <= cmd_rdy_d;
      mv_err_q <= mv_err_d;
    end
  end
  assign bus.mv_indx = mv_indx_q;
  assign bus.cmd = cmd_q;
  assign bus.cmd_rdy = cmd_rdy_q;
  assign bus.tour_done = (state_q == DONE);
  assign bus.mv_err = mv_err_q;
endmodule

// File: tb/tb_tour_cmd.sv
// tb_tour_cmd: randomized scoreboard bench for tour_cmd
module tb_tour_cmd;
  localparam int N = 24;
`ifdef TOUR_CMD_FANFARE_EN
  localparam logic [3:0] OP_H = 4'h3;
`else
  localparam logic [3:0] OP_H = 4'h2;
`endif
  typedef struct packed {logic [15:0] cmd; logic [4:0] idx;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  tour_cmd_if bus();
  tour_cmd #(.NUM_MOVES(N)) dut (.clk(clk), .rst(rst), .bus(bus));
  exp_t exp_q[$];
  int done_q[$];
  int nvec = 0;
  int nerr = 0;
  logic [7:0] tbl [32];
  int dx_t [8] = '{1, -1, -2, -2, -1, 1, 2, 2};
  int dy_t [8] = '{2, 2, 1, -1, -2, -2, -1, 1};
  // solver move store: registered read of the presented index
  always @(posedge clk) bus.move <= tbl[bus.mv_indx];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [15:0] leg(input logic [7:0] m, input bit horz);
    int i = 0;
    int d;
    for (int b = 0; b < 8; b++) if (m[b]) i = b;
    d = horz ? dx_t[i] : dy_t[i];
    if (horz) return {OP_H, d > 0 ? 8'hBF : 8'h3F, 4'(d < 0 ? -d : d)};
    return {4'h2, d > 0 ? 8'h00 : 8'h7F, 4'(d < 0 ? -d : d)};
  endfunction
  exp_t e;
  logic [15:0] held;
  bit rdy_seen = 0;
  bit done_seen = 0;
  always @(negedge clk) begin
    if (bus.cmd_rdy === 1'b1) begin
      if (rdy_seen) check("cmd_hold", bus.cmd, held);
      else if (exp_q.size() == 0) check("cmd_unexpected", bus.cmd_rdy, 0);
      else begin
        e = exp_q.pop_front();
        check("cmd", bus.cmd, e.cmd);
        check("cmd_idx", bus.mv_indx, e.idx);
      end
      held = bus.cmd;
    end
    rdy_seen = (bus.cmd_rdy === 1'b1);
    if (bus.tour_done === 1'b1) begin
      if (done_seen) check("done_width", bus.tour_done, 0);
      else if (done_q.size() == 0) check("done_unexpected", bus.tour_done, 0);
      else check("done_idx", bus.mv_indx, done_q.pop_front());
    end
    done_seen = (bus.tour_done === 1'b1);
  end
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic pulse_start();
    bus.start_tour = 1'b1;
    cyc(1);
    bus.start_tour = 1'b0;
  endtask
  task automatic pulse_resp();
    bus.resp_rdy = 1'b1;
    cyc(1);
    bus.resp_rdy = 1'b0;
  endtask
  task automatic wait_rdy(output bit ok, output int lat);
    ok = 0;
    lat = 0;
    for (int i = 0; i < 30; i++) begin
      if (bus.cmd_rdy === 1'b1) begin
        ok = 1;
        break;
      end
      cyc(1);
      lat++;
    end
    if (!ok) check("rdy_timeout", bus.cmd_rdy, 1);
  endtask
  task automatic leg_hs(input bit do_resp);
    cyc($urandom_range(0, 2));
    if ($urandom_range(0, 2) == 0) pulse_resp();
    bus.clr_cmd_rdy = 1'b1;
    bus.resp_rdy = ($urandom_range(0, 2) == 0);
    cyc(1);
    bus.clr_cmd_rdy = 1'b0;
    bus.resp_rdy = 1'b0;
    check("rdy_drop", bus.cmd_rdy, 0);
    if (!do_resp) return;
    cyc($urandom_range(0, 3));
    if ($urandom_range(0, 2) == 0) pulse_start();
    pulse_resp();
  endtask
  task automatic run_tour(input int abort_at);
    bit ok;
    int lat;
    for (int k = 0; k < N; k++) begin
      exp_q.push_back({leg(tbl[k], 0), 5'(k)});
      exp_q.push_back({leg(tbl[k], 1), 5'(k)});
    end
    done_q.push_back(N - 1);
    pulse_start();
    check("err_clr", bus.mv_err, 0);
    for (int k = 0; k < N; k++) begin
      for (int l = 0; l < 2; l++) begin
        wait_rdy(ok, lat);
        if (!ok) begin
          exp_q.delete();
          done_q.delete();
          return;
        end
        if (k == 0 && l == 0) check("latency", lat, 3);
        if (k == abort_at && l == 0) begin
          leg_hs(0);
          rst = 1'b1;
          cyc(1);
          rst = 1'b0;
          exp_q.delete();
          done_q.delete();
          check("rst_indx", bus.mv_indx, 0);
          check("rst_cmd", bus.cmd, 0);
          check("rst_rdy", bus.cmd_rdy, 0);
          check("rst_done", bus.tour_done, 0);
          check("rst_err", bus.mv_err, 0);
          repeat (3) begin
            cyc(2);
            pulse_resp();
          end
          cyc(10);
          check("post_rst_indx", bus.mv_indx, 0);
          check("post_rst_rdy", bus.cmd_rdy, 0);
          return;
        end
        leg_hs(1);
      end
    end
    for (int i = 0; i < 5 && bus.tour_done !== 1'b1; i++) cyc(1);
    check("done_seen", bus.tour_done, 1);
    cyc(1);
    check("done_clear", bus.tour_done, 0);
    check("idle_indx", bus.mv_indx, N - 1);
    check("done_q", done_q.size(), 0);
  endtask
  task automatic err_test(input logic [7:0] m);
    tbl[0] = m;
    pulse_start();
    cyc(4);
    check("mv_err", bus.mv_err, 1);
    check("err_no_rdy", bus.cmd_rdy, 0);
    cyc(6);
    check("mv_err_sticky", bus.mv_err, 1);
    check("err_indx", bus.mv_indx, 0);
  endtask
  task automatic rand_tbl();
    for (int k = 0; k < 32; k++) tbl[k] = 8'h01 << $urandom_range(0, 7);
  endtask
  initial begin
    bus.start_tour = 1'b0;
    bus.clr_cmd_rdy = 1'b0;
    bus.resp_rdy = 1'b0;
    rand_tbl();
    tbl[0] = 8'h01;
    tbl[1] = 8'h08;
    cyc(3);
    check("reset_indx", bus.mv_indx, 0);
    check("reset_cmd", bus.cmd, 0);
    check("reset_rdy", bus.cmd_rdy, 0);
    check("reset_done", bus.tour_done, 0);
    check("reset_err", bus.mv_err, 0);
    rst = 1'b0;
    cyc(2);
    pulse_resp();
    bus.clr_cmd_rdy = 1'b1;
    cyc(1);
    bus.clr_cmd_rdy = 1'b0;
    cyc(3);
    check("idle_ignore_rdy", bus.cmd_rdy, 0);
    run_tour(-1);
    err_test(8'h03);
    rand_tbl();
    run_tour(-1);
    err_test(8'h00);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check("rst_clears_err", bus.mv_err, 0);
    err_test(8'hFF);
    rand_tbl();
    run_tour(5);
    rand_tbl();
    run_tour(-1);
    cyc(5);
    check("exp_q_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/tour_cmd.md
TOUR_CMD -- requirements
Module: tour_cmd

Interface
REQ-001 Parameter NUM_MOVES, default 24: number of tour moves to replay; mv_indx counts 0..NUM_MOVES-1.
REQ-002 clk  input  1  single system clock; all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start_tour  input  1  one-cycle pulse from the tour solver's done; begins replay.
REQ-005 mv_indx  output  5  move index presented to the solver's move store.
REQ-006 move  input  8  one-hot move read from the solver; registered there, valid the cycle after mv_indx changes.
REQ-007 cmd  output  16  robot command: [15:12] opcode, [11:4] heading, [3:0] square count.
REQ-008 cmd_rdy  output  1  cmd valid; held until clr_cmd_rdy.
REQ-009 clr_cmd_rdy  input  1  consumer accepted cmd.
REQ-010 resp_rdy  input  1  one-cycle pulse: robot finished the current command.
REQ-011 tour_done  output  1  one-cycle pulse after the last command completes.
REQ-012 mv_err  output  1  sticky flag: a non-one-hot move was read.

Function
REQ-013 States SHALL be IDLE, FETCH, LOAD, VERT, VWAIT, HORZ, HWAIT, DONE.
REQ-014 IDLE: start_tour=1 -> FETCH with mv_indx=0; start_tour in any other state SHALL be ignored.
REQ-015 FETCH: one cycle with mv_indx stable -> LOAD; LOAD latches move into an internal register -> VERT.
REQ-016 Latency: cmd_rdy SHALL rise 3 clocks after the edge sampling start_tour.
REQ-017 Move decode (dx,dy): bit0(+1,+2) bit1(-1,+2) bit2(-2,+1) bit3(-2,-1) bit4(-1,-2) bit5(+1,-2) bit6(+2,-1) bit7(+2,+1).
REQ-018 Headings: north 8'h00, west 8'h3F, south 8'h7F, east 8'hBF; opcode 4'h2 = move.
REQ-019 VERT: cmd = {4'h2, dy>0 ? north : south, |dy|}; cmd_rdy=1 until clr_cmd_rdy, then -> VWAIT.
REQ-020 VWAIT: resp_rdy -> HORZ; HORZ: cmd = {op2, dx>0 ? east : west, |dx|} (op2 per REQ-029), same handshake -> HWAIT.
REQ-021 HWAIT: resp_rdy with mv_indx<NUM_MOVES-1 -> increment mv_indx -> FETCH; with mv_indx=NUM_MOVES-1 -> DONE.
REQ-022 DONE: tour_done=1 for exactly one cycle -> IDLE; mv_indx held.
REQ-023 resp_rdy outside VWAIT/HWAIT SHALL be ignored; clr_cmd_rdy outside VERT/HORZ SHALL be ignored.
REQ-024 clr_cmd_rdy and resp_rdy in the same VERT/HORZ cycle: resp_rdy ignored; a later resp_rdy is required.
REQ-025 LOAD with a zero or multi-hot move: mv_err=1, no command issued, -> IDLE; mv_err cleared only by rst or the next accepted start_tour.
REQ-026 cmd SHALL be held constant while cmd_rdy=1.

Reset
REQ-027 rst=1 at any edge, including mid-handshake: state=IDLE; mv_indx=0, cmd=16'h0000, cmd_rdy=0, tour_done=0, mv_err=0, move register=0.
REQ-028 After rst, the block SHALL issue no command until a new start_tour.

Configuration
REQ-029 Macro TOUR_CMD_FANFARE_EN: defined -> op2 = 4'h3 (move with fanfare), i.e. the horizontal leg of each move carries fanfare; undefined -> op2 = 4'h2; all other behaviour is identical.

Verification
REQ-030 start_tour, move[0]=8'h01, clr and resp after each cmd -> cmd 16'h2002, then 16'h3BF1 (16'h2BF1 without macro); cmd_rdy high 3 clocks after start_tour.
REQ-031 move=8'h08 -> cmd 16'h27F1, then 16'h33F2 (16'h23F2 without macro).
REQ-032 Full 24-move replay with valid moves -> 48 commands, mv_indx 0..23 in order, a single tour_done pulse after the 48th resp_rdy, then IDLE.
REQ-033 move=8'h03 at mv_indx=0 -> mv_err=1, cmd_rdy never asserted, IDLE; next start_tour clears mv_err.
REQ-034 rst in VWAIT at mv_indx=5 -> all outputs at reset values next cycle; later resp_rdy pulses produce no activity.
REQ-035 resp_rdy pulses in IDLE and in VERT before clr_cmd_rdy, plus a second start_tour in VWAIT -> no state advance.
